// File: rtl/aim_pos_decoder_if.sv
// Handshake/bus bundle for aim_pos_decoder: batch load inputs and the chunk-map stream.
// o_hits exists only when AIM_DEC_HITS_EN is defined.
interface aim_pos_decoder_if #(
    parameter int N_ENTRY = 32,
    parameter int POS_W   = 9,
    parameter int CHUNK_W = 4
);
    logic                            i_start;
    logic [CHUNK_W-1:0]              i_ite;
    logic [N_ENTRY-1:0]              i_valid;
    logic [N_ENTRY-1:0][POS_W-1:0]   i_pos;
    logic                            o_busy;
    logic                            o_map_valid;
    logic                            i_map_ready;
    logic [N_ENTRY-1:0]              o_map;
    logic [CHUNK_W-1:0]              o_chunk;
    logic                            o_dup;
    logic                            o_oob;
    logic                            o_finish;
`ifdef AIM_DEC_HITS_EN
    logic [5:0]                      o_hits;
`endif

    modport master (
        output i_start, i_ite, i_valid, i_pos, i_map_ready,
        input  o_busy, o_map_valid, o_map, o_chunk, o_dup, o_oob, o_finish
`ifdef AIM_DEC_HITS_EN
        , input o_hits
`endif
    );

    modport slave (
        input  i_start, i_ite, i_valid, i_pos, i_map_ready,
        output o_busy, o_map_valid, o_map, o_chunk, o_dup, o_oob, o_finish
`ifdef AIM_DEC_HITS_EN
        , output o_hits
`endif
    );
endinterface

// File: rtl/aim_pos_decoder.sv
// Expands one latched batch of 32 (valid,pos) matches into per-chunk 32-bit occupancy maps.
// Optional AIM_DEC_HITS_EN adds a registered per-chunk popcount on o_hits.
module aim_pos_decoder (
    input  logic              i_clk,
    input  logic              i_rst_n,
    aim_pos_decoder_if.slave  bus
);
    localparam int N_ENTRY = 32;
    localparam int POS_W   = 9;
    localparam int LANE_W  = 5;
    localparam int CHUNK_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_e;

    state_e                          state_q;
    logic [N_ENTRY-1:0]              valid_q;
    logic [N_ENTRY-1:0][POS_W-1:0]   pos_q;
    logic [CHUNK_W-1:0]              ite_q;
    logic [CHUNK_W-1:0]              chunk_q;
    logic [N_ENTRY-1:0]              map_q,  map_d;
    logic                            dup_q,  dup_d;
    logic                            oob_q,  oob_d;
    logic                            busy_q;
    logic                            map_valid_q;
    logic                            finish_q;
    logic [CHUNK_W-1:0]              sel_chunk;
`ifdef AIM_DEC_HITS_EN
    logic [5:0]                      hits_q, hits_d;
`endif

    // Next map is always prepared for the chunk that follows the one on display:
    // chunk 0 while loading, chunk_q+1 while emitting.
    always_comb begin
        sel_chunk = (state_q == S_EMIT) ? chunk_q + 1'b1 : '0;
        map_d     = '0;
        dup_d     = 1'b0;
        oob_d     = 1'b0;
`ifdef AIM_DEC_HITS_EN
        hits_d    = '0;
`endif
        for (int e = 0; e < N_ENTRY; e++) begin
            if (valid_q[e]) begin
                if (pos_q[e][POS_W-1:LANE_W] == sel_chunk) begin
                    if (map_d[pos_q[e][LANE_W-1:0]]) dup_d = 1'b1;
                    map_d[pos_q[e][LANE_W-1:0]] = 1'b1;
`ifdef AIM_DEC_HITS_EN
                    hits_d = hits_d + 6'd1;
`endif
                end
                if (pos_q[e][POS_W-1:LANE_W] > ite_q) oob_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            pos_q       <= '0;
            ite_q       <= '0;
            chunk_q     <= '0;
            map_q       <= '0;
            dup_q       <= 1'b0;
            oob_q       <= 1'b0;
            busy_q      <= 1'b0;
            map_valid_q <= 1'b0;
            finish_q    <= 1'b0;
`ifdef AIM_DEC_HITS_EN
            hits_q      <= '0;
`endif
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        valid_q <= bus.i_valid;
                        pos_q   <= bus.i_pos;
                        ite_q   <= bus.i_ite;
                        chunk_q <= '0;
                        oob_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    map_q       <= map_d;
                    dup_q       <= dup_d;
                    oob_q       <= oob_d;
                    map_valid_q <= 1'b1;
`ifdef AIM_DEC_HITS_EN
                    hits_q      <= hits_d;
`endif
                    state_q     <= S_EMIT;
                end
                S_EMIT: begin
                    if (map_valid_q && bus.i_map_ready) begin
                        if (chunk_q == ite_q) begin
                            map_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            finish_q    <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            chunk_q <= chunk_q + 1'b1;
                            map_q   <= map_d;
                            dup_q   <= dup_d;
`ifdef AIM_DEC_HITS_EN
                            hits_q  <= hits_d;
`endif
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_map_valid = map_valid_q;
    assign bus.o_map       = map_q;
    assign bus.o_chunk     = chunk_q;
    assign bus.o_dup       = dup_q;
    assign bus.o_oob       = oob_q;
    assign bus.o_finish    = finish_q;
`ifdef AIM_DEC_HITS_EN
    assign bus.o_hits      = hits_q;
`endif
endmodule

// File: tb/tb_aim_pos_decoder.sv
// Self-checking bench for aim_pos_decoder: vector table + scoreboard, plus
// back-to-back, reset-abort and latency sequences.
module tb_aim_pos_decoder;
    logic i_clk;
    logic i_rst_n;

    aim_pos_decoder_if bus();

    aim_pos_decoder dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  chunk;
        logic [31:0] map;
        logic        dup;
        logic [5:0]  hits;
    } exp_t;

    typedef struct {
        string            name;
        logic [31:0]      valid;
        logic [31:0][8:0] pos;
        logic [3:0]       ite;
        int               stall_chunk;
        int               stall_n;
        logic             exp_oob;
        logic [31:0]      exp_last;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    vec_t        vecs[7];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_map;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Reference model: per-lane hit counts for each emitted chunk.
    task automatic push_exp(input logic [31:0] v, input logic [31:0][8:0] p, input logic [3:0] ite);
        exp_t e;
        int   cnt;
        for (int c = 0; c <= int'(ite); c++) begin
            e.chunk = 4'(c);
            e.map   = '0;
            e.dup   = 1'b0;
            e.hits  = '0;
            for (int l = 0; l < 32; l++) begin
                cnt = 0;
                for (int k = 0; k < 32; k++)
                    if (v[k] && int'(p[k]) == c * 32 + l) cnt++;
                if (cnt > 0) e.map[l] = 1'b1;
                if (cnt > 1) e.dup = 1'b1;
                e.hits = e.hits + 6'(cnt);
            end
            exp_q.push_back(e);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n && bus.o_map_valid && bus.i_map_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got chunk=%0d want none", bus.o_chunk);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_chunk", 64'(bus.o_chunk), 64'(mon_e.chunk));
                chk("sb_map",   64'(bus.o_map),   64'(mon_e.map));
                chk("sb_dup",   64'(bus.o_dup),   64'(mon_e.dup));
`ifdef AIM_DEC_HITS_EN
                chk("sb_hits",  64'(bus.o_hits),  64'(mon_e.hits));
`endif
                last_map = bus.o_map;
            end
        end
    end

    // Called #1 after the edge that latched start; runs until o_finish.
    task automatic drive_until_finish(input int stall_chunk, input int stall_n,
                                      input int exp_cycles, input string nm);
        int          n    = 0;
        int          left = stall_n;
        logic        held = 1'b0;
        logic        done = 1'b0;
        logic [31:0] hmap = '0;
        logic [3:0]  hchk = '0;
        bus.i_map_ready = 1'b1;
        while (!done && n < 200) begin
            @(posedge i_clk); #1;
            n++;
            if (n == 1) chk({nm, "_first_chunk"}, {62'(bus.o_chunk), bus.o_map_valid, 1'b0}, 64'h2);
            if (held) begin
                chk({nm, "_hold_map"},   64'(bus.o_map),   64'(hmap));
                chk({nm, "_hold_chunk"}, 64'(bus.o_chunk), 64'(hchk));
            end
            if (bus.o_finish) begin
                done = 1'b1;
            end else if (bus.o_map_valid && int'(bus.o_chunk) == stall_chunk && left > 0) begin
                bus.i_map_ready = 1'b0;
                left--;
                held = 1'b1;
                hmap = bus.o_map;
                hchk = bus.o_chunk;
            end else begin
                bus.i_map_ready = 1'b1;
                held = 1'b0;
            end
        end
        chk({nm, "_finish_cycles"}, 64'(n), 64'(exp_cycles));
        chk({nm, "_finish_state"}, {61'd0, bus.o_finish, bus.o_map_valid, bus.o_busy}, 64'h4);
    endtask

    task automatic scramble_inputs();
        bus.i_valid = $urandom;
        bus.i_ite   = 4'($urandom);
        for (int e = 0; e < 32; e++) bus.i_pos[e] = 9'($urandom);
    endtask

    task automatic run_vec(input vec_t v);
        push_exp(v.valid, v.pos, v.ite);
        bus.i_valid = v.valid;
        bus.i_pos   = v.pos;
        bus.i_ite   = v.ite;
        bus.i_start = 1'b1;
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
        chk({v.name, "_load"}, {62'd0, bus.o_busy, bus.o_map_valid}, 64'h2);
        scramble_inputs();
        drive_until_finish(v.stall_chunk, v.stall_n, int'(v.ite) + 2 + v.stall_n, v.name);
        chk({v.name, "_oob"},  64'(bus.o_oob),  64'(v.exp_oob));
        chk({v.name, "_last"}, 64'(last_map),   64'(v.exp_last));
        chk({v.name, "_drain"}, 64'(exp_q.size()), 64'd0);
        @(posedge i_clk); #1;
        chk({v.name, "_finish_pulse"}, 64'(bus.o_finish), 64'd0);
    endtask

    initial begin
        logic             found;
        logic [31:0][8:0] p;
        vec_t             a, b;

        for (int i = 0; i < 7; i++) begin
            vecs[i].valid = '0; vecs[i].pos = '0; vecs[i].ite = '0;
            vecs[i].stall_chunk = -1; vecs[i].stall_n = 0;
            vecs[i].exp_oob = 1'b0; vecs[i].exp_last = '0;
        end
        // single hit; invalid entries share the pos and must be ignored
        vecs[0].name = "single";
        for (int e = 0; e < 32; e++) vecs[0].pos[e] = 9'd37;
        vecs[0].valid = 32'h1; vecs[0].ite = 4'd1; vecs[0].exp_last = 32'h0000_0020;
        vecs[1].name = "dup";
        for (int e = 0; e < 32; e++) vecs[1].pos[e] = 9'd5;
        vecs[1].valid = 32'h88; vecs[1].ite = 4'd0; vecs[1].exp_last = 32'h0000_0020;
        vecs[2].name = "bp";
        for (int e = 0; e < 32; e++) vecs[2].pos[e] = 9'(e + 32 * (e % 3));
        vecs[2].valid = '1; vecs[2].ite = 4'd2; vecs[2].stall_chunk = 1; vecs[2].stall_n = 3;
        vecs[2].exp_last = 32'h2492_4924;
        vecs[3].name = "oob";
        vecs[3].pos[4] = 9'd200; vecs[3].valid = 32'h10; vecs[3].ite = 4'd3; vecs[3].exp_oob = 1'b1;
        vecs[4].name = "allinv";
        for (int e = 0; e < 32; e++) vecs[4].pos[e] = 9'(e * 13);
        vecs[4].ite = 4'd15;
        vecs[5].name = "full";
        for (int e = 0; e < 32; e++) vecs[5].pos[e] = 9'(480 + e);
        vecs[5].valid = '1; vecs[5].ite = 4'd15; vecs[5].exp_last = 32'hFFFF_FFFF;
        vecs[6].name = "ite0oob";
        for (int e = 0; e < 32; e++) vecs[6].pos[e] = 9'(e * 16);
        vecs[6].valid = '1; vecs[6].ite = 4'd0; vecs[6].exp_oob = 1'b1;
        vecs[6].exp_last = 32'h0001_0001;

        i_rst_n = 1'b0;
        bus.i_start = 1'b0; bus.i_ite = '0; bus.i_valid = '0; bus.i_pos = '0;
        bus.i_map_ready = 1'b0;
        last_map = '0;
        #1;
        chk("reset_outs", {bus.o_map, 27'd0, bus.o_chunk, bus.o_busy, bus.o_map_valid,
                           bus.o_dup, bus.o_oob, bus.o_finish}, 64'd0);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // back-to-back: start held through A; B presented after A is latched
        a = vecs[0]; b = vecs[1];
        push_exp(a.valid, a.pos, a.ite);
        bus.i_valid = a.valid; bus.i_pos = a.pos; bus.i_ite = a.ite; bus.i_start = 1'b1;
        @(posedge i_clk); #1;
        push_exp(b.valid, b.pos, b.ite);
        bus.i_valid = b.valid; bus.i_pos = b.pos; bus.i_ite = b.ite;
        drive_until_finish(-1, 0, int'(a.ite) + 2, "b2bA");
        chk("b2bA_last", 64'(last_map), 64'(a.exp_last));
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
        chk("b2bB_load", {62'd0, bus.o_busy, bus.o_finish}, 64'h2);
        drive_until_finish(-1, 0, int'(b.ite) + 2, "b2bB");
        chk("b2bB_last", 64'(last_map), 64'(b.exp_last));
        chk("b2b_drain", 64'(exp_q.size()), 64'd0);
        @(posedge i_clk); #1;

        // reset abort while chunk 2 is on display
        for (int e = 0; e < 32; e++) p[e] = 9'(e * 9);
        push_exp('1, p, 4'd3);
        bus.i_valid = '1; bus.i_pos = p; bus.i_ite = 4'd3; bus.i_start = 1'b1;
        bus.i_map_ready = 1'b1;
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge i_clk); #1;
            if (bus.o_map_valid && bus.o_chunk == 4'd2) found = 1'b1;
        end
        chk("abort_reach_chunk2", 64'(found), 64'd1);
        i_rst_n = 1'b0;
        #1;
        chk("abort_outs", {bus.o_map, 27'd0, bus.o_chunk, bus.o_busy, bus.o_map_valid,
                           bus.o_dup, bus.o_oob, bus.o_finish}, 64'd0);
        exp_q.delete();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge i_clk); #1;
            if (bus.o_finish || bus.o_map_valid) found = 1'b1;
        end
        chk("abort_no_finish", 64'(found), 64'd0);
        b = vecs[6];
        b.name = "post_abort";
        run_vec(b);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1);
    end
endmodule

// File: doc/aim_pos_decoder.md
# aim_pos_decoder

Inverse of the associative index-match encoder path. It latches one batch of 32 (valid, pos) match results and expands it back into per-chunk 32-bit one-hot occupancy maps over the input-activation channel space, one chunk per handshake. It sits downstream of the matcher and feeds the sparse-gather / tracking datapath, which consumes maps under backpressure.

## Interface
- N_ENTRY, 32: entries per batch; fixed lane count of the matcher.
- POS_W, 9: pos width; pos[8:5] is the chunk index, pos[4:0] is the lane.
- i_clk  in  1  clock. One clock, rising edge.
- i_rst_n  in  1  reset. Asynchronous, active-low.
- i_start  in  1  batch-load strobe. Sampled only in S_IDLE.
- i_ite  in  4  last chunk index to emit; chunks 0..i_ite are emitted. Latched at start.
- i_valid[0:31]  in  1 each  entry valid flags.
- i_pos[0:31]  in  9 each  entry positions.
- o_busy  out  1  high in S_LOAD and S_EMIT.
- o_map_valid  out  1  o_map/o_chunk/o_dup hold a chunk.
- i_map_ready  in  1  consumer accepts the chunk.
- o_map  out  32  one-hot/multi-hot occupancy of the current chunk; bit l = lane l.
- o_chunk  out  4  index of the current chunk.
- o_dup  out  1  two or more valid entries hit the same bit in this chunk.
- o_oob  out  1  sticky per batch: some valid entry has pos[8:5] > latched ite.
- o_finish  out  1  one-cycle pulse after the last chunk is accepted.
- o_hits  out  6  popcount of valid entries landing in this chunk. Present only with AIM_DEC_HITS_EN.

## Operation
- States: S_IDLE, S_LOAD, S_EMIT.
- S_IDLE -> S_LOAD on i_start. The cycle i_start is high, the block registers i_valid, i_pos, i_ite, clears the chunk counter, and clears o_oob.
- S_LOAD (1 cycle): computes o_oob from the registered entries. -> S_EMIT.
- S_EMIT: map bit l is set iff some valid entry has pos == {chunk, l[4:0]}.
  - o_dup is set iff at least two valid entries share a pos inside the current chunk.
  - Entries with valid=0 are ignored regardless of pos.
- Handshake: a transfer occurs when o_map_valid && i_map_ready.
  - On transfer with chunk < ite: chunk increments and the state stays in S_EMIT.
  - On transfer with chunk == ite: -> S_IDLE, o_finish=1 for that next cycle.
- o_map/o_chunk/o_dup must stay stable while o_map_valid && !i_map_ready.
- i_start outside S_IDLE is ignored. Input changes after the load cycle have no effect.
- Out-of-range entries (chunk > ite) never appear in any map. They only set o_oob.
- i_ite = 0 emits exactly one chunk. i_ite = 15 emits 16 chunks and covers the full 9-bit pos space, so o_oob cannot assert.
- All-invalid batch: every chunk is emitted with o_map = 0, o_dup = 0.

## Timing
- Reset (async assert, sync to clock on release): state S_IDLE, o_busy=0, o_map_valid=0, o_map=0, o_chunk=0, o_dup=0, o_oob=0, o_finish=0, o_hits=0, latched entries cleared.
- Latency: i_start at cycle T -> o_busy=1 at T+1 (S_LOAD) -> o_map_valid=1 with chunk 0 at T+2.
- Throughput: one chunk per cycle with i_map_ready held high. A batch of ite+1 chunks occupies ite+3 cycles from start to o_finish.
- o_map, o_dup and o_hits are registered outputs, updated on the transfer edge for the next chunk. There is no combinational path from i_map_ready to o_map.
- o_map_valid drops in the cycle o_finish pulses. A new i_start is accepted in that same cycle (back-to-back batches).
- Reset mid-batch aborts immediately. No o_finish is produced.

## Configuration
- AIM_DEC_HITS_EN defined: o_hits port exists, registered alongside o_map, and equals the number of valid entries mapping into the current chunk, duplicates counted (0..32).
- AIM_DEC_HITS_EN undefined: o_hits port and its popcount logic are absent. All other behaviour is identical.

## Test plan
- Single hit: valid[0]=1, pos[0]=9'd37, ite=1, ready=1 -> chunk0 map=0, chunk1 map=32'h00000020, o_dup=0, o_oob=0, o_finish 4 cycles after start.
- Duplicates: entries 3 and 7 both valid with pos 9'd5, ite=0 -> map=32'h00000020, o_dup=1, o_hits=2 (with AIM_DEC_HITS_EN).
- Backpressure: ite=2, all 32 valid with pos=lane+32*(lane%3), ready low for 3 cycles on chunk 1 -> chunk-1 map held stable. Chunk sequence is 0,1,2 with no loss; o_finish only after the chunk-2 transfer.
- Out of range: valid[4]=1, pos[4]=9'd200, ite=3 -> all four maps zero, o_oob=1 from S_EMIT until the next start.
- Back-to-back plus ignored start: i_start held high through batch A -> batch B loads in A's o_finish cycle. Mid-batch starts do not alter A's maps.
- Reset abort: assert i_rst_n=0 while o_map_valid=1 on chunk 2 -> all outputs 0 asynchronously. A subsequent start with ite=0 emits normally.
